// File: rtl/multicycle_controller_if.sv
// Bus between the multicycle controller and its datapath/memory environment.
// Parameter: RETIRE_W - width of the retired-instruction counter.
// Signals:
//   Opcode[6:0], Zero, mem_ready          environment -> controller
//   mem_req, IRWrite, PCWrite, ALUSrc,
//   MemtoReg, RegWrite, MemRead, MemWrite,
//   ALUOp[1:0], state[2:0],
//   retire_count[RETIRE_W-1:0],
//   err_illegal, err_timeout              controller -> environment
// Modports: master (the controller), slave (the environment).
interface multicycle_controller_if #(
  parameter int unsigned RETIRE_W = 32
);
  logic [6:0]          Opcode;
  logic                Zero;
  logic                mem_ready;
  logic                mem_req;
  logic                IRWrite;
  logic                PCWrite;
  logic                ALUSrc;
  logic                MemtoReg;
  logic                RegWrite;
  logic                MemRead;
  logic                MemWrite;
  logic [1:0]          ALUOp;
  logic [2:0]          state;
  logic [RETIRE_W-1:0] retire_count;
  logic                err_illegal;
  logic                err_timeout;

  modport master (
    input  Opcode, Zero, mem_ready,
    output mem_req, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
           MemRead, MemWrite, ALUOp, state, retire_count,
           err_illegal, err_timeout
  );

  modport slave (
    output Opcode, Zero, mem_ready,
    input  mem_req, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
           MemRead, MemWrite, ALUOp, state, retire_count,
           err_illegal, err_timeout
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle instruction controller: FETCH -> DECODE -> EXEC -> (MEM) -> WB.
// Parameters:
//   MEM_TIMEOUT - max waiting cycles per memory access (1..255)
//   RETIRE_W    - width of retire_count (must match the bus RETIRE_W)
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - multicycle_controller_if.master (opcode/flags/mem handshake in,
//           datapath controls, debug state, retire count, error pulses out)
// Optional feature: define MC_BRANCH_EN to decode opcode 1100011 as a branch;
// otherwise it is an illegal opcode.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned RETIRE_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multicycle_controller_if.master  bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

`ifdef MC_BRANCH_EN
  localparam logic BRANCH_EN = 1'b1;
`else
  localparam logic BRANCH_EN = 1'b0;
`endif

  typedef enum logic [2:0] {CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH} cls_e;

  logic [2:0]          r_state, w_state_nxt;
  cls_e                r_cls, w_cls_nxt;
  logic [7:0]          r_wait;
  logic [RETIRE_W-1:0] r_retire;

  logic       w_timeout, w_retire;
  logic       w_mem_req, w_irwrite, w_pcwrite, w_alusrc, w_memtoreg;
  logic       w_regwrite, w_memread, w_memwrite, w_err_illegal;
  logic [1:0] w_aluop;

  // Zero only steers the external branch-target mux; the controller itself
  // updates the PC unconditionally for a branch.
  logic w_unused_zero;
  assign w_unused_zero = bus.Zero;

  always_comb begin
    w_state_nxt   = r_state;
    w_cls_nxt     = r_cls;
    w_timeout     = 1'b0;
    w_retire      = 1'b0;
    w_mem_req     = 1'b0;
    w_irwrite     = 1'b0;
    w_pcwrite     = 1'b0;
    w_alusrc      = 1'b0;
    w_memtoreg    = 1'b0;
    w_regwrite    = 1'b0;
    w_memread     = 1'b0;
    w_memwrite    = 1'b0;
    w_aluop       = 2'b00;
    w_err_illegal = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (r_wait == TIMEOUT) begin
          w_timeout   = 1'b1;
          w_pcwrite   = 1'b1;
          w_state_nxt = S_FETCH;
        end else begin
          w_mem_req = 1'b1;
          w_memread = 1'b1;
          if (bus.mem_ready) begin
            w_irwrite   = 1'b1;
            w_state_nxt = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        w_state_nxt = S_EXEC;
        case (bus.Opcode)
          OP_R:     w_cls_nxt = CL_R;
          OP_I:     w_cls_nxt = CL_I;
          OP_LOAD:  w_cls_nxt = CL_LOAD;
          OP_STORE: w_cls_nxt = CL_STORE;
          OP_BRANCH: begin
            if (BRANCH_EN) begin
              w_cls_nxt = CL_BRANCH;
            end else begin
              w_err_illegal = 1'b1;
              w_pcwrite     = 1'b1;
              w_state_nxt   = S_FETCH;
            end
          end
          default: begin
            w_err_illegal = 1'b1;
            w_pcwrite     = 1'b1;
            w_state_nxt   = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        case (r_cls)
          CL_R: begin
            w_aluop     = 2'b10;
            w_state_nxt = S_WB;
          end
          CL_I: begin
            w_aluop     = 2'b00;
            w_alusrc    = 1'b1;
            w_state_nxt = S_WB;
          end
          CL_LOAD, CL_STORE: begin
            w_aluop     = 2'b01;
            w_alusrc    = 1'b1;
            w_state_nxt = S_MEM;
          end
          CL_BRANCH: begin
            w_aluop     = 2'b11;
            w_pcwrite   = 1'b1;
            w_retire    = 1'b1;
            w_state_nxt = S_FETCH;
          end
          default: w_state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (r_wait == TIMEOUT) begin
          w_timeout   = 1'b1;
          w_pcwrite   = 1'b1;
          w_state_nxt = S_FETCH;
        end else begin
          w_mem_req  = 1'b1;
          w_memread  = (r_cls == CL_LOAD);
          w_memwrite = (r_cls == CL_STORE);
          if (bus.mem_ready) begin
            if (r_cls == CL_STORE) begin
              w_pcwrite   = 1'b1;
              w_retire    = 1'b1;
              w_state_nxt = S_FETCH;
            end else if (r_cls == CL_LOAD) begin
              w_state_nxt = S_WB;
            end else begin
              w_state_nxt = S_FETCH;
            end
          end
        end
      end
      S_WB: begin
        w_regwrite  = 1'b1;
        w_pcwrite   = 1'b1;
        w_memtoreg  = (r_cls == CL_LOAD);
        w_retire    = 1'b1;
        w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_FETCH;
      r_cls    <= CL_R;
      r_wait   <= '0;
      r_retire <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cls   <= w_cls_nxt;
      // Any state change (and a timeout re-entering FETCH) starts a fresh
      // wait; only FETCH and MEM ever hold, so only they accumulate.
      if ((w_state_nxt != r_state) || w_timeout) begin
        r_wait <= '0;
      end else if (!bus.mem_ready) begin
        r_wait <= r_wait + 8'd1;
      end
      if (w_retire) begin
        r_retire <= r_retire + RETIRE_W'(1);
      end
    end
  end

  // Outputs are forced low while rst_n is held so that reset is visible
  // immediately, independent of the registered state.
  assign bus.mem_req      = rst_n & w_mem_req;
  assign bus.IRWrite      = rst_n & w_irwrite;
  assign bus.PCWrite      = rst_n & w_pcwrite;
  assign bus.ALUSrc       = rst_n & w_alusrc;
  assign bus.MemtoReg     = rst_n & w_memtoreg;
  assign bus.RegWrite     = rst_n & w_regwrite;
  assign bus.MemRead      = rst_n & w_memread;
  assign bus.MemWrite     = rst_n & w_memwrite;
  assign bus.ALUOp        = rst_n ? w_aluop : '0;
  assign bus.err_illegal  = rst_n & w_err_illegal;
  assign bus.err_timeout  = rst_n & w_timeout;
  assign bus.state        = rst_n ? r_state : '0;
  assign bus.retire_count = rst_n ? r_retire : '0;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller (MEM_TIMEOUT=4).
// A second instance with RETIRE_W=2 shares the stimulus to exercise counter
// wrap. Honors MC_BRANCH_EN for the branch-opcode expectations.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_controller_if #(.RETIRE_W(32)) ifc ();
  multicycle_controller_if #(.RETIRE_W(2))  ifc2 ();

  assign ifc2.Opcode    = ifc.Opcode;
  assign ifc2.Zero      = ifc.Zero;
  assign ifc2.mem_ready = ifc.mem_ready;

  multicycle_controller #(.MEM_TIMEOUT(4), .RETIRE_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc.master));
  multicycle_controller #(.MEM_TIMEOUT(4), .RETIRE_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(ifc2.master));

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_ILL = 7'b1111111;

  // Packed view: {state[2:0], mem_req, IRWrite, PCWrite, ALUSrc, MemtoReg,
  //               RegWrite, MemRead, MemWrite, ALUOp[1:0], err_illegal, err_timeout}
  localparam logic [14:0] MREQ = 15'(1) << 11;
  localparam logic [14:0] IRW  = 15'(1) << 10;
  localparam logic [14:0] PCW  = 15'(1) << 9;
  localparam logic [14:0] ASRC = 15'(1) << 8;
  localparam logic [14:0] M2R  = 15'(1) << 7;
  localparam logic [14:0] RW   = 15'(1) << 6;
  localparam logic [14:0] MRD  = 15'(1) << 5;
  localparam logic [14:0] MWR  = 15'(1) << 4;
  localparam logic [14:0] EIL  = 15'(1) << 1;
  localparam logic [14:0] ETO  = 15'(1) << 0;

  function automatic logic [14:0] st(input int unsigned s);
    return 15'(s) << 12;
  endfunction
  function automatic logic [14:0] aop(input int unsigned a);
    return 15'(a) << 2;
  endfunction

  logic [14:0] w_act;
  assign w_act = {ifc.state, ifc.mem_req, ifc.IRWrite, ifc.PCWrite, ifc.ALUSrc,
                  ifc.MemtoReg, ifc.RegWrite, ifc.MemRead, ifc.MemWrite,
                  ifc.ALUOp, ifc.err_illegal, ifc.err_timeout};

  typedef struct {
    logic        rst_n;
    logic [6:0]  op;
    logic        zero;
    logic        rdy;
    logic [14:0] exp;
    int unsigned rc;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic add(input logic r, input logic [6:0] op, input logic z,
                     input logic rdy, input logic [14:0] e,
                     input int unsigned rc, input string nm);
    vec_t v;
    v.rst_n = r; v.op = op; v.zero = z; v.rdy = rdy;
    v.exp = e; v.rc = rc; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [6:0] op, input logic z, input logic rdy);
    @(negedge clk);
    rst_n         = r;
    ifc.Opcode    = op;
    ifc.Zero      = z;
    ifc.mem_ready = rdy;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rc;
    ifc.Opcode    = '0;
    ifc.Zero      = 1'b0;
    ifc.mem_ready = 1'b0;

    rc = 0;
    add(0, OP_R, 0, 1, '0, rc, "reset0");
    add(0, OP_R, 0, 1, '0, rc, "reset1");
    // R-type, ready immediately
    add(1, OP_R, 0, 1, st(0)|MREQ|IRW|MRD, rc, "R fetch");
    add(1, OP_R, 0, 1, st(1),              rc, "R decode");
    add(1, OP_R, 0, 1, st(2)|aop(2),       rc, "R exec");
    add(1, OP_R, 0, 1, st(4)|RW|PCW,       rc, "R wb"); rc++;
    // I-type, one fetch wait
    add(1, OP_I, 0, 0, st(0)|MREQ|MRD,        rc, "I fetch wait");
    add(1, OP_I, 0, 1, st(0)|MREQ|IRW|MRD,    rc, "I fetch");
    add(1, OP_I, 0, 1, st(1),                 rc, "I decode");
    add(1, OP_I, 0, 1, st(2)|ASRC|aop(0),     rc, "I exec");
    add(1, OP_I, 0, 1, st(4)|RW|PCW,          rc, "I wb"); rc++;
    // Load, stray ready in DECODE/EXEC, 3 wait cycles in MEM
    add(1, OP_LD, 0, 1, st(0)|MREQ|IRW|MRD,   rc, "LD fetch");
    add(1, OP_LD, 0, 1, st(1),                rc, "LD decode");
    add(1, OP_LD, 0, 1, st(2)|ASRC|aop(1),    rc, "LD exec");
    for (int i = 0; i < 3; i++)
      add(1, OP_LD, 0, 0, st(3)|MREQ|MRD,     rc, "LD mem wait");
    add(1, OP_LD, 0, 1, st(3)|MREQ|MRD,       rc, "LD mem");
    add(1, OP_LD, 0, 1, st(4)|RW|PCW|M2R,     rc, "LD wb"); rc++;
    // Store
    add(1, OP_ST, 0, 1, st(0)|MREQ|IRW|MRD,   rc, "ST fetch");
    add(1, OP_ST, 0, 1, st(1),                rc, "ST decode");
    add(1, OP_ST, 0, 1, st(2)|ASRC|aop(1),    rc, "ST exec");
    add(1, OP_ST, 0, 1, st(3)|MREQ|MWR|PCW,   rc, "ST mem"); rc++;
    // Branch opcode
    add(1, OP_BR, 0, 1, st(0)|MREQ|IRW|MRD,   rc, "BR fetch");
`ifdef MC_BRANCH_EN
    add(1, OP_BR, 1, 1, st(1),                rc, "BR decode");
    add(1, OP_BR, 1, 1, st(2)|aop(3)|PCW,     rc, "BR exec"); rc++;
`else
    add(1, OP_BR, 1, 1, st(1)|EIL|PCW,        rc, "BR illegal");
`endif
    // Illegal opcode
    add(1, OP_ILL, 0, 1, st(0)|MREQ|IRW|MRD,  rc, "ILL fetch");
    add(1, OP_ILL, 0, 1, st(1)|EIL|PCW,       rc, "ILL decode");
    // FETCH timeout after 4 waiting cycles
    for (int i = 0; i < 4; i++)
      add(1, OP_ST, 0, 0, st(0)|MREQ|MRD,     rc, "fetch wait");
    add(1, OP_ST, 0, 0, st(0)|PCW|ETO,        rc, "fetch timeout");
    // MEM timeout on a store; late ready in the timeout cycle is ignored
    add(1, OP_ST, 0, 1, st(0)|MREQ|IRW|MRD,   rc, "ST2 fetch");
    add(1, OP_ST, 0, 0, st(1),                rc, "ST2 decode");
    add(1, OP_ST, 0, 0, st(2)|ASRC|aop(1),    rc, "ST2 exec");
    for (int i = 0; i < 4; i++)
      add(1, OP_ST, 0, 0, st(3)|MREQ|MWR,     rc, "ST2 mem wait");
    add(1, OP_ST, 0, 1, st(3)|PCW|ETO,        rc, "mem timeout");
    add(1, OP_LD, 0, 1, st(0)|MREQ|IRW|MRD,   rc, "LD2 fetch");

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst_n, vecs[i].op, vecs[i].zero, vecs[i].rdy);
      chk($sformatf("%s[%0d] outputs", vecs[i].name, i), 32'(w_act), 32'(vecs[i].exp));
      chk($sformatf("%s[%0d] retire_count", vecs[i].name, i), ifc.retire_count, vecs[i].rc);
      chk($sformatf("%s[%0d] retire_count_w2", vecs[i].name, i),
          32'(ifc2.retire_count), vecs[i].rc % 4);
    end

    // Reset in the middle of a load's MEM wait
    apply(1, OP_LD, 0, 0);
    chk("midload decode state", 32'(ifc.state), 32'd1);
    apply(1, OP_LD, 0, 0);
    chk("midload exec state", 32'(ifc.state), 32'd2);
    apply(1, OP_LD, 0, 0);
    chk("midload mem outputs", 32'(w_act), 32'(st(3)|MREQ|MRD));
    apply(0, OP_LD, 0, 1);
    chk("reset asserted outputs", 32'(w_act), 32'd0);
    apply(0, OP_LD, 0, 1);
    chk("after reset outputs", 32'(w_act), 32'd0);
    chk("after reset retire_count", ifc.retire_count, 32'd0);
    chk("after reset retire_count_w2", 32'(ifc2.retire_count), 32'd0);
    apply(1, OP_R, 0, 0);
    chk("reset release mem_req", 32'(w_act), 32'(st(0)|MREQ|MRD));
    chk("reset release retire_count", ifc.retire_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
